// File: rtl/team_06_gpio_ctrl_pkg.sv
// Shared types and register indices for the team_06 GPIO controller.
package team_06_gpio_pkg;

   localparam logic [2:0] REG_OUT_LO = 3'd0;
   localparam logic [2:0] REG_OUT_HI = 3'd1;
   localparam logic [2:0] REG_OEB_LO = 3'd2;
   localparam logic [2:0] REG_OEB_HI = 3'd3;
   localparam logic [2:0] REG_IN_LO  = 3'd4;
   localparam logic [2:0] REG_IN_HI  = 3'd5;
   localparam logic [2:0] REG_OWN_LO = 3'd6;
   localparam logic [2:0] REG_OWN_HI = 3'd7;

   typedef enum logic {IDLE, ACK} arb_state_t;
   typedef enum logic {GNT_WB, GNT_LA} grant_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/team_06_gpio_ctrl_if.sv
// Wishbone slave bus bundle between the team_06 bus wrapper and the GPIO controller.
interface team_06_gpio_ctrl_if;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic        we_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;
   logic [31:0] dat_o;

   modport master (
      output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
      input  ack_o, dat_o
   );

   modport slave (
      input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
      output ack_o, dat_o
   );
endinterface

// File: rtl/team_06_gpio_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs, parameterized width.
module team_06_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/team_06_gpio_ctrl.sv
// GPIO register file and pin mux shared by a Wishbone slave and an LA side-port
// through a two-state round-robin arbiter (one access per grant, ack one cycle later).
module team_06_gpio_ctrl
   import team_06_gpio_pkg::*;
#(
   parameter int          NUM_GPIO  = 34,
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
   input  logic                clk_i,
   input  logic                nrst_i,
   team_06_gpio_ctrl_if.slave  wb,
   input  logic                la_req,
   input  logic                la_we,
   input  logic [2:0]          la_addr,
   input  logic [31:0]         la_wdata,
   output logic                la_ack,
   output logic [31:0]         la_rdata,
   input  logic [NUM_GPIO-1:0] core_out,
   input  logic [NUM_GPIO-1:0] core_oeb,
   output logic [NUM_GPIO-1:0] core_in,
   input  logic [NUM_GPIO-1:0] gpio_in,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic [NUM_GPIO-1:0] gpio_oeb
);

   localparam int HI_W = NUM_GPIO - 32;

   logic [NUM_GPIO-1:0] out_q, out_d;
   logic [NUM_GPIO-1:0] oeb_q, oeb_d;
   logic [NUM_GPIO-1:0] own_q, own_d;
   logic [NUM_GPIO-1:0] in_sync;
   arb_state_t          state_q;
   grant_t              last_q;
   grant_t              gnt_d;
   logic                wb_hit;
   logic                req_any;
   logic                do_write;
   logic [2:0]          acc_idx;
   logic [31:0]         acc_wdata;
   logic [3:0]          acc_be;
   logic [31:0]         rd_word;
   logic [31:0]         wr_word;
   logic [63:0]         out64, oeb64, own64, in64;
   logic                unused_adr;

   assign unused_adr = ^wb.adr_i[1:0];

   team_06_sync2 #(.WIDTH(NUM_GPIO)) u_sync (
      .clk_i (clk_i),
      .nrst_i(nrst_i),
      .d_i   (gpio_in),
      .q_o   (in_sync)
   );

   assign core_in  = in_sync;
   assign gpio_out = (own_q & core_out) | (~own_q & out_q);
   assign gpio_oeb = (own_q & core_oeb) | (~own_q & oeb_q);

   assign out64 = {{(64-NUM_GPIO){1'b0}}, out_q};
   assign oeb64 = {{(64-NUM_GPIO){1'b0}}, oeb_q};
   assign own64 = {{(64-NUM_GPIO){1'b0}}, own_q};
   assign in64  = {{(64-NUM_GPIO){1'b0}}, in_sync};

   assign wb_hit  = wb.cyc_i & wb.stb_i & (wb.adr_i[31:5] == ADDR_BASE[31:5]);
   assign req_any = wb_hit | la_req;

   // A tie goes to whichever requester was not served last.
   always_comb begin
      gnt_d = GNT_WB;
      if (wb_hit && la_req) begin
         gnt_d = (last_q == GNT_LA) ? GNT_WB : GNT_LA;
      end else if (la_req) begin
         gnt_d = GNT_LA;
      end
   end

   always_comb begin
      if (gnt_d == GNT_LA) begin
         acc_idx   = la_addr;
         acc_wdata = la_wdata;
         acc_be    = 4'hF;
         do_write  = (state_q == IDLE) && la_req && la_we;
      end else begin
         acc_idx   = wb.adr_i[4:2];
         acc_wdata = wb.dat_i;
         acc_be    = wb.sel_i;
         do_write  = (state_q == IDLE) && wb_hit && wb.we_i;
      end
   end

   always_comb begin
      case (acc_idx)
         REG_OUT_LO: rd_word = out64[31:0];
         REG_OUT_HI: rd_word = out64[63:32];
         REG_OEB_LO: rd_word = oeb64[31:0];
         REG_OEB_HI: rd_word = oeb64[63:32];
         REG_IN_LO:  rd_word = in64[31:0];
         REG_IN_HI:  rd_word = in64[63:32];
         REG_OWN_LO: rd_word = own64[31:0];
         default:    rd_word = own64[63:32];
      endcase
   end

   assign wr_word = be_merge(rd_word, acc_wdata, acc_be);

   // IN_LO/IN_HI fall through to the default arm: acknowledged, not stored.
   always_comb begin
      out_d = out_q;
      oeb_d = oeb_q;
      own_d = own_q;
      if (do_write) begin
         case (acc_idx)
            REG_OUT_LO: out_d[31:0]          = wr_word;
            REG_OUT_HI: out_d[NUM_GPIO-1:32] = wr_word[HI_W-1:0];
            REG_OEB_LO: oeb_d[31:0]          = wr_word;
            REG_OEB_HI: oeb_d[NUM_GPIO-1:32] = wr_word[HI_W-1:0];
            REG_OWN_LO: own_d[31:0]          = wr_word;
            REG_OWN_HI: own_d[NUM_GPIO-1:32] = wr_word[HI_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         out_q    <= '0;
         oeb_q    <= '1;
         own_q    <= '0;
         state_q  <= IDLE;
         last_q   <= GNT_LA;
         wb.ack_o <= 1'b0;
         wb.dat_o <= '0;
         la_ack   <= 1'b0;
         la_rdata <= '0;
      end else begin
         out_q <= out_d;
         oeb_q <= oeb_d;
         own_q <= own_d;
         if (state_q == IDLE) begin
            if (req_any) begin
               state_q <= ACK;
               last_q  <= gnt_d;
               if (gnt_d == GNT_WB) begin
                  wb.ack_o <= 1'b1;
                  wb.dat_o <= rd_word;
               end else begin
                  la_ack   <= 1'b1;
                  la_rdata <= rd_word;
               end
            end
         end else begin
            wb.ack_o <= 1'b0;
            la_ack   <= 1'b0;
            state_q  <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_team_06_gpio_ctrl.sv
// Directed bench for team_06_gpio_ctrl: registers, pin mux, arbitration, sync and reset.
module tb_team_06_gpio_ctrl;
   import team_06_gpio_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        la_req, la_we, la_ack;
   logic [2:0]  la_addr;
   logic [31:0] la_wdata, la_rdata;
   logic [33:0] core_out, core_oeb, core_in, gpio_in, gpio_out, gpio_oeb;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   team_06_gpio_ctrl_if wb();

   team_06_gpio_ctrl dut (
      .clk_i   (clk),
      .nrst_i  (nrst),
      .wb      (wb),
      .la_req  (la_req),
      .la_we   (la_we),
      .la_addr (la_addr),
      .la_wdata(la_wdata),
      .la_ack  (la_ack),
      .la_rdata(la_rdata),
      .core_out(core_out),
      .core_oeb(core_oeb),
      .core_in (core_in),
      .gpio_in (gpio_in),
      .gpio_out(gpio_out),
      .gpio_oeb(gpio_oeb)
   );

   task automatic bus_idle();
      wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.sel_i = 0;
      wb.adr_i = 0; wb.dat_i = 0;
      la_req = 0; la_we = 0; la_addr = 0; la_wdata = 0;
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat, output logic ok);
      logic a1, a2;
      @(posedge clk); #1;
      wb.adr_i = adr; wb.we_i = we; wb.dat_i = wdat; wb.sel_i = sel;
      wb.cyc_i = 1; wb.stb_i = 1;
      @(posedge clk); #1;
      a1 = wb.ack_o; rdat = wb.dat_o;
      wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0;
      @(posedge clk); #1;
      a2 = wb.ack_o;
      ok = a1 & ~a2;
   endtask

   task automatic la_xfer(input logic [2:0] idx, input logic we, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic ok);
      logic a1, a2;
      @(posedge clk); #1;
      la_addr = idx; la_we = we; la_wdata = wdat; la_req = 1;
      @(posedge clk); #1;
      a1 = la_ack; rdat = la_rdata;
      la_req = 0; la_we = 0;
      @(posedge clk); #1;
      a2 = la_ack;
      ok = a1 & ~a2;
   endtask

   task automatic do_reset();
      nrst = 0;
      repeat (3) @(posedge clk);
      #1 nrst = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic ok;
      bus_idle();
      core_out = '0; core_oeb = '1; gpio_in = '0;
      do_reset();
      n_checks++; if (gpio_oeb !== 34'h3_FFFF_FFFF) begin n_fail++; $display("FAIL reset_oeb: got %h expected 3ffffffff", gpio_oeb); end
      n_checks++; if (gpio_out !== 34'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", gpio_out); end
      n_checks++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wb.ack_o); end
      n_checks++; if (la_ack !== 1'b0) begin n_fail++; $display("FAIL reset_la_ack: got %b expected 0", la_ack); end
      n_checks++; if (wb.dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat_o: got %h expected 0", wb.dat_o); end
      wb_xfer(BASE + 32'h8, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ack: got %b expected 1", ok); end
      n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_oeb_lo: got %h expected ffffffff", rd); end
      wb_xfer(BASE + 32'hC, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL reset_oeb_hi: got %h expected 3", rd); end
      la_xfer(REG_OWN_LO, 1'b0, 32'h0, rd, ok);
      n_checks++; if (ok !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL reset_own_lo: got ack %b data %h expected ack 1 data 0", ok, rd); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      logic ok;
      wb_xfer(BASE + 32'h0, 1'b1, 32'hA5A5_A5A5, 4'b0011, rd, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lanes_ack_pulse: got %b expected 1", ok); end
      wb_xfer(BASE + 32'h0, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h0000_A5A5) begin n_fail++; $display("FAIL lanes_out_lo: got %h expected 0000a5a5", rd); end
      n_checks++; if (gpio_out[31:0] !== 32'h0000_A5A5) begin n_fail++; $display("FAIL lanes_pins: got %h expected 0000a5a5", gpio_out[31:0]); end
      wb_xfer(BASE + 32'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ok);
      wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL lanes_out_hi: got %h expected 3", rd); end
      wb_xfer(BASE + 32'h4, 1'b1, 32'h0, 4'b1110, rd, ok);
      wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL lanes_hi_masked: got %h expected 3", rd); end
      wb_xfer(BASE + 32'h4, 1'b1, 32'h0, 4'hF, rd, ok);
   endtask

   task automatic test_ownership();
      logic [31:0] rd;
      logic ok;
      wb_xfer(BASE + 32'h18, 1'b1, 32'h1, 4'hF, rd, ok);
      wb_xfer(BASE + 32'h8, 1'b1, 32'h0, 4'hF, rd, ok);
      n_checks++; if (gpio_out[0] !== 1'b0 || gpio_oeb[0] !== 1'b1) begin n_fail++; $display("FAIL own_core_idle: got out %b oeb %b expected out 0 oeb 1", gpio_out[0], gpio_oeb[0]); end
      core_out[0] = 1'b1; core_oeb[0] = 1'b0; #1;
      n_checks++; if (gpio_out[0] !== 1'b1 || gpio_oeb[0] !== 1'b0) begin n_fail++; $display("FAIL own_core_drive: got out %b oeb %b expected out 1 oeb 0", gpio_out[0], gpio_oeb[0]); end
      n_checks++; if (gpio_out[1] !== 1'b0 || gpio_oeb[1] !== 1'b0) begin n_fail++; $display("FAIL own_pin1_sw: got out %b oeb %b expected out 0 oeb 0", gpio_out[1], gpio_oeb[1]); end
      wb_xfer(BASE + 32'h0, 1'b1, 32'h0000_00FE, 4'b0001, rd, ok);
      n_checks++; if (gpio_out[1:0] !== 2'b11) begin n_fail++; $display("FAIL own_pin1_follow: got %b expected 11", gpio_out[1:0]); end
      la_xfer(REG_OUT_LO, 1'b0, 32'h0, rd, ok);
      n_checks++; if (rd !== 32'h0000_A5FE) begin n_fail++; $display("FAIL own_out_lo: got %h expected 0000a5fe", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, held;
      logic ok;
      logic exp_wb;
      bus_idle();
      core_out = '0; core_oeb = '1;
      do_reset();
      @(posedge clk); #1;
      wb.adr_i = BASE + 32'h4; wb.dat_i = 32'h1; wb.sel_i = 4'hF; wb.we_i = 1;
      wb.cyc_i = 1; wb.stb_i = 1;
      la_addr = REG_OEB_HI; la_wdata = 32'h0; la_we = 1; la_req = 1;
      for (int k = 0; k < 4; k++) begin
         exp_wb = (k % 2 == 0);
         @(posedge clk); #1;
         n_checks++; if (wb.ack_o !== exp_wb || la_ack !== !exp_wb) begin n_fail++; $display("FAIL b2b_grant%0d: got wb %b la %b expected wb %b la %b", k, wb.ack_o, la_ack, exp_wb, !exp_wb); end
         @(posedge clk); #1;
         n_checks++; if (wb.ack_o !== 1'b0 || la_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: got wb %b la %b expected 0 0", k, wb.ack_o, la_ack); end
      end
      bus_idle();
      la_xfer(REG_OUT_HI, 1'b0, 32'h0, rd, ok);
      n_checks++; if (ok !== 1'b1 || rd !== 32'h1) begin n_fail++; $display("FAIL b2b_out_hi: got ack %b data %h expected ack 1 data 1", ok, rd); end
      held = rd;
      @(posedge clk); #1;
      n_checks++; if (la_rdata !== held) begin n_fail++; $display("FAIL b2b_la_hold: got %h expected %h", la_rdata, held); end
      wb_xfer(BASE + 32'hC, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL b2b_oeb_hi: got %h expected 0", rd); end
      n_checks++; if (gpio_out[33:32] !== 2'b01 || gpio_oeb[33:32] !== 2'b00) begin n_fail++; $display("FAIL b2b_pins_hi: got out %b oeb %b expected out 01 oeb 00", gpio_out[33:32], gpio_oeb[33:32]); end
   endtask

   task automatic test_sync();
      logic [31:0] rd;
      logic ok;
      @(posedge clk); #1;
      gpio_in[33] = 1'b1; gpio_in[3:0] = 4'hA;
      @(posedge clk); #1;
      n_checks++; if (core_in[33] !== 1'b0) begin n_fail++; $display("FAIL sync_cycle1: got %b expected 0", core_in[33]); end
      @(posedge clk); #1;
      n_checks++; if (core_in[33] !== 1'b1) begin n_fail++; $display("FAIL sync_cycle2: got %b expected 1", core_in[33]); end
      wb_xfer(BASE + 32'h14, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL sync_in_hi: got %h expected 2", rd); end
      la_xfer(REG_IN_LO, 1'b0, 32'h0, rd, ok);
      n_checks++; if (rd !== 32'hA) begin n_fail++; $display("FAIL sync_in_lo: got %h expected a", rd); end
      la_xfer(REG_IN_HI, 1'b1, 32'h0, rd, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sync_ro_ack: got %b expected 1", ok); end
      wb_xfer(BASE + 32'h14, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL sync_ro_keep: got %h expected 2", rd); end
      gpio_in[33] = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (core_in[33] !== 1'b1) begin n_fail++; $display("FAIL sync_fall1: got %b expected 1", core_in[33]); end
      @(posedge clk); #1;
      n_checks++; if (core_in[33] !== 1'b0) begin n_fail++; $display("FAIL sync_fall2: got %b expected 0", core_in[33]); end
   endtask

   task automatic test_window();
      logic seen;
      logic [31:0] addrs [2];
      addrs[0] = BASE + 32'h20;
      addrs[1] = BASE - 32'h4;
      for (int a = 0; a < 2; a++) begin
         @(posedge clk); #1;
         wb.adr_i = addrs[a]; wb.we_i = 0; wb.sel_i = 4'hF; wb.cyc_i = 1; wb.stb_i = 1;
         seen = 1'b0;
         for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (wb.ack_o === 1'b1) seen = 1'b1;
         end
         n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL window_%0d: got ack %b expected 0 for %h", a, seen, addrs[a]); end
         bus_idle();
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic ok;
      n_checks++; if (gpio_oeb[32] !== 1'b0) begin n_fail++; $display("FAIL mid_precond: got oeb32 %b expected 0", gpio_oeb[32]); end
      @(posedge clk); #1;
      wb.adr_i = BASE; wb.dat_i = 32'hFFFF_FFFF; wb.sel_i = 4'hF; wb.we_i = 1;
      wb.cyc_i = 1; wb.stb_i = 1;
      @(posedge clk); #1;
      n_checks++; if (wb.ack_o !== 1'b1) begin n_fail++; $display("FAIL mid_ack_before: got %b expected 1", wb.ack_o); end
      nrst = 0;
      #1;
      n_checks++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL mid_ack_cleared: got %b expected 0", wb.ack_o); end
      n_checks++; if (gpio_oeb !== 34'h3_FFFF_FFFF || gpio_out !== 34'h0) begin n_fail++; $display("FAIL mid_pins: got oeb %h out %h expected 3ffffffff 0", gpio_oeb, gpio_out); end
      n_checks++; if (wb.dat_o !== 32'h0) begin n_fail++; $display("FAIL mid_dat_o: got %h expected 0", wb.dat_o); end
      bus_idle();
      @(posedge clk); #1;
      nrst = 1;
      wb_xfer(BASE, 1'b0, 32'h0, 4'hF, rd, ok);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_out_lo: got %h expected 0", rd); end
      la_xfer(REG_OEB_HI, 1'b0, 32'h0, rd, ok);
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL mid_oeb_hi: got %h expected 3", rd); end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_ownership();
      test_back_to_back();
      test_sync();
      test_window();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
